// File: rtl/serial_magnitude_comparator.sv
// Bit-serial unsigned magnitude comparator, MSB-first, one bit per clock, valid/ready on both sides.
// Define SERIAL_CMP_EARLY_EXIT_EN to finish as soon as the first differing bit is seen.
module serial_magnitude_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             smaller,
  output logic             equal,
  output logic             greater
);
  // state | meaning
  // IDLE  | waiting for an operand pair
  // BUSY  | comparing one bit per cycle, MSB first
  // DONE  | result presented until out_ready
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             decided_q, decided_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;
  logic             a_msb, b_msb, first_diff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      gt_q      <= gt_d;
      lt_q      <= lt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    cnt_d      = cnt_q;
    decided_d  = decided_q;
    gt_d       = gt_q;
    lt_d       = lt_q;
    a_msb      = a_sh_q[WIDTH-1];
    b_msb      = b_sh_q[WIDTH-1];
    first_diff = !decided_q && (a_msb != b_msb);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d   = BUSY;
          a_sh_d    = a;
          b_sh_d    = b;
          cnt_d     = CW'(WIDTH - 1);
          decided_d = 1'b0;
          gt_d      = 1'b0;
          lt_d      = 1'b0;
        end
      end
      BUSY: begin
        if (first_diff) begin
          decided_d = 1'b1;
          gt_d      = a_msb & ~b_msb;
          lt_d      = ~a_msb & b_msb;
        end
        a_sh_d = a_sh_q << 1;
        b_sh_d = b_sh_q << 1;
        // Counter parks at zero on the final bit so it never wraps.
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        if (first_diff) begin
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign smaller   = (state_q == DONE) & lt_q;
  assign greater   = (state_q == DONE) & gt_q;
  assign equal     = (state_q == DONE) & ~decided_q;

endmodule
